// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Merges the ID-stage
//   hazard flag, the EXE-stage branch decision and the MEM-stage memory
//   handshake into freeze/flush controls. A two-state FSM holds the whole
//   pipeline while a data-memory access is outstanding. Two saturating
//   counters record stall cycles and branch flushes.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   hazard          : ID-stage RAW hazard
//   branch_taken    : EXE-stage branch resolved taken
//   mem_req         : MEM-stage instruction needs data memory
//   mem_ready       : single-cycle pulse, memory access complete
//   cnt_clr         : synchronous clear of both counters
//   mem_start       : one-cycle pulse launching a memory access
//   freeze_if       : hold PC and IF/ID
//   freeze_all      : hold PC and every pipeline register
//   flush_if_id     : bubble into IF/ID
//   flush_id_exe    : bubble into ID/EXE
//   mem_busy        : FSM is waiting on memory (registered)
//   stall_cnt       : cycles with any freeze asserted (saturating)
//   flush_cnt       : branch flushes (saturating)
module pipeline_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             mem_start,
  output logic             freeze_if,
  output logic             freeze_all,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + 1'b1;
  endfunction

  // Next state and combinational controls
  always_comb begin
    state_d      = state_q;
    mem_start    = 1'b0;
    freeze_if    = 1'b0;
    freeze_all   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          // Memory access wins; hazard/branch re-resolve after the release.
          if (mem_req) begin
            mem_start  = 1'b1;
            freeze_all = 1'b1;
            state_d    = MEM_WAIT;
          end else if (branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
          end else if (hazard) begin
            freeze_if    = 1'b1;
            flush_id_exe = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Release on the ready cycle so the pipeline advances on that edge.
          if (mem_ready) state_d = RUN;
          else           freeze_all = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (freeze_if || freeze_all) stall_cnt_d = sat_inc(stall_cnt_q);
      if (flush_if_id)             flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_busy  = (state_q == MEM_WAIT);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0, cnt_clr = 1'b0;
  logic mem_start, freeze_if, freeze_all, flush_if_id, flush_id_exe, mem_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .mem_start(mem_start), .freeze_if(freeze_if), .freeze_all(freeze_all),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe), .mem_busy(mem_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  // Behavioural model: "an access is outstanding" flag plus integer counters.
  bit model_on = 1'b0;
  bit m_waiting = 1'b0;
  int m_stalls = 0;
  int m_flushes = 0;

  always @(negedge clk) begin
    if (model_on) begin
      bit e_start, e_fif, e_fall, e_fl1, e_fl2;
      e_start = 0; e_fif = 0; e_fall = 0; e_fl1 = 0; e_fl2 = 0;
      if (!rst) begin
        if (m_waiting) e_fall = !mem_ready;
        else if (mem_req) begin e_start = 1; e_fall = 1; end
        else if (branch_taken) begin e_fl1 = 1; e_fl2 = 1; end
        else if (hazard) begin e_fif = 1; e_fl2 = 1; end
      end
      check("mdl_mem_start", int'(mem_start), int'(e_start));
      check("mdl_freeze_if", int'(freeze_if), int'(e_fif));
      check("mdl_freeze_all", int'(freeze_all), int'(e_fall));
      check("mdl_flush_if_id", int'(flush_if_id), int'(e_fl1));
      check("mdl_flush_id_exe", int'(flush_id_exe), int'(e_fl2));
      check("mdl_mem_busy", int'(mem_busy), int'(m_waiting));
      check("mdl_stall_cnt", int'(stall_cnt), m_stalls);
      check("mdl_flush_cnt", int'(flush_cnt), m_flushes);
      // advance the model across the coming rising edge
      if (rst) begin
        m_waiting = 0; m_stalls = 0; m_flushes = 0;
      end else begin
        m_waiting = m_waiting ? !mem_ready : mem_req;
        if (cnt_clr) begin
          m_stalls = 0; m_flushes = 0;
        end else begin
          if ((e_fif || e_fall) && m_stalls < CMAX) m_stalls++;
          if (e_fl1 && m_flushes < CMAX) m_flushes++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_start[4] = '{1, 0, 1, 0};
  int exp_busy[4]  = '{0, 1, 0, 1};

  initial begin
    cyc();
    model_on = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(mem_busy), 0);
    check("reset_stall", int'(stall_cnt), 0);
    check("reset_flush", int'(flush_cnt), 0);

    // Hazard only, two cycles
    cyc();
    hazard = 1'b1;
    @(negedge clk);
    check("hz_freeze_if", int'(freeze_if), 1);
    check("hz_flush_id_exe", int'(flush_id_exe), 1);
    check("hz_flush_if_id", int'(flush_if_id), 0);
    cyc(); cyc();
    hazard = 1'b0;
    @(negedge clk);
    check("hz_stall_cnt", int'(stall_cnt), 2);
    check("hz_flush_cnt", int'(flush_cnt), 0);

    // Branch beats hazard
    cyc();
    hazard = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    check("br_flush_if_id", int'(flush_if_id), 1);
    check("br_flush_id_exe", int'(flush_id_exe), 1);
    check("br_freeze_if", int'(freeze_if), 0);
    cyc();
    hazard = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    check("br_flush_cnt", int'(flush_cnt), 1);
    check("br_stall_cnt", int'(stall_cnt), 2);

    // Memory wait, ready 3 cycles after start, branch held throughout
    cyc();
    mem_req = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    check("mw_start", int'(mem_start), 1);
    check("mw_freeze_all0", int'(freeze_all), 1);
    check("mw_noflush0", int'(flush_if_id), 0);
    cyc();
    mem_req = 1'b0;
    @(negedge clk);
    check("mw_start_once", int'(mem_start), 0);
    check("mw_freeze_all1", int'(freeze_all), 1);
    check("mw_busy", int'(mem_busy), 1);
    cyc(); cyc();
    mem_ready = 1'b1;
    @(negedge clk);
    check("mw_release", int'(freeze_all), 0);
    check("mw_noflush_rel", int'(flush_if_id), 0);
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    check("mw_branch_after", int'(flush_if_id), 1);
    check("mw_busy_low", int'(mem_busy), 0);
    check("mw_stall_cnt", int'(stall_cnt), 5);
    cyc();
    branch_taken = 1'b0;

    // Back-to-back accesses, ready one cycle after each start
    cyc();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i % 2 == 1);
      @(negedge clk);
      check("b2b_start", int'(mem_start), exp_start[i]);
      check("b2b_busy", int'(mem_busy), exp_busy[i]);
      cyc();
    end
    mem_req = 1'b0; mem_ready = 1'b0;

    // Saturation and clear
    cyc();
    hazard = 1'b1;
    repeat (20) cyc();
    @(negedge clk);
    check("sat_stall", int'(stall_cnt), 15);
    cyc();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0; hazard = 1'b0;
    @(negedge clk);
    check("clr_stall", int'(stall_cnt), 0);
    check("clr_busy", int'(mem_busy), 0);

    // Reset while waiting on memory; stray ready afterwards does nothing
    cyc();
    mem_req = 1'b1;
    cyc();
    mem_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_no_start", int'(mem_start), 0);
    check("rst_no_freeze", int'(freeze_all), 0);
    cyc();
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(mem_busy), 0);
    check("rst_stall", int'(stall_cnt), 0);
    check("rst_flush", int'(flush_cnt), 0);
    cyc();
    mem_ready = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    #1;
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage ARM pipeline. It combines the hazard detection unit's `Hazard` flag, the EXE-stage branch decision and the MEM-stage memory handshake into per-stage freeze and flush controls. A small FSM holds the whole pipeline while a data-memory access is outstanding. Saturating counters record stall and flush activity for performance debug.

## Interface

Parameters:
- `CNT_W`, default 16: width of the stall and flush counters.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `hazard`, input, 1: `Hazard` from the hazard detection unit (ID-stage RAW hazard).
- `branch_taken`, input, 1: EXE-stage branch resolved taken.
- `mem_req`, input, 1: MEM-stage instruction needs data memory (`MEM_R_EN | MEM_W_EN`).
- `mem_ready`, input, 1: memory controller access complete; single-cycle pulse.
- `cnt_clr`, input, 1: synchronous clear of both counters.
- `mem_start`, output, 1: one-cycle pulse that launches a memory access.
- `freeze_if`, output, 1: hold the PC and the IF/ID register.
- `freeze_all`, output, 1: hold the PC and every pipeline register.
- `flush_if_id`, output, 1: load a bubble into IF/ID.
- `flush_id_exe`, output, 1: load a bubble into ID/EXE.
- `mem_busy`, output, 1: FSM is in MEM_WAIT.
- `stall_cnt`, output, CNT_W: cycles with `freeze_if` or `freeze_all` asserted.
- `flush_cnt`, output, CNT_W: number of branch flushes.

## Operation

FSM has two states, RUN and MEM_WAIT. Reset state is RUN.

RUN:
- `mem_req`=1: assert `mem_start`=1 and `freeze_all`=1; next state MEM_WAIT. Hazard and branch outputs are suppressed this cycle. `mem_ready` is ignored in RUN.
- Otherwise, if `branch_taken`=1: assert `flush_if_id`=1 and `flush_id_exe`=1, with `freeze_if`=0 so the PC loads the target.
- Otherwise, if `hazard`=1: assert `freeze_if`=1 and `flush_id_exe`=1 (bubble insertion).
- Priority is mem_req > branch_taken > hazard.

MEM_WAIT:
- `mem_busy`=1.
- `freeze_all`=1 while `mem_ready`=0. `freeze_all`=0 in the cycle `mem_ready`=1, so the pipeline advances on that edge; next state RUN.
- `mem_start`, `freeze_if` and both flushes are 0 throughout MEM_WAIT, including the release cycle. A branch or hazard that was frozen re-resolves after release.
- `mem_start` is never re-issued inside MEM_WAIT.

Back-to-back accesses: if the instruction arriving in MEM after release also has `mem_req`, RUN issues a new `mem_start` in the first RUN cycle. The minimum cost is 2 cycles per access.

Counters:
- `stall_cnt` increments by 1 in each cycle where `freeze_if|freeze_all`=1.
- `flush_cnt` increments by 1 in each cycle where `flush_if_id`=1.
- Both saturate at 2^CNT_W−1 and do not wrap.
- `cnt_clr` zeroes both counters and takes priority over an increment in the same cycle. `cnt_clr` does not affect the FSM.

Reset:
- Returns the FSM to RUN and zeroes both counters.
- While `rst`=1, all control outputs are forced to 0.
- Reset during MEM_WAIT abandons the access. No `mem_start` is emitted on exit from reset unless `mem_req` is sampled in RUN.

## Timing

- `mem_start`, `freeze_if`, `freeze_all`, `flush_if_id` and `flush_id_exe` are combinational from the current state and inputs, valid in the same cycle.
- `mem_busy`, `stall_cnt` and `flush_cnt` are registered.
  - Counters reflect a cycle's event one clock later.
  - `mem_busy` rises the cycle after `mem_start` and falls the cycle after `mem_ready`.
- Reset values: state RUN, `mem_busy`=0, `stall_cnt`=0, `flush_cnt`=0. All combinational outputs are 0 while `rst`=1.
- Access latency as seen by the pipeline is 1 + N cycles, where `mem_ready` arrives N cycles after `mem_start`.
- `mem_ready` arriving in RUN, or after `rst`, has no effect.

## Test plan

- Reset in MEM_WAIT: `mem_req`=1, then `rst`=1 for 1 cycle while `mem_ready`=0 → `mem_busy`=0 and counters 0 after the edge; no `mem_start` pulse while `rst`=1.
- Hazard only: `hazard`=1 for 2 cycles, all other inputs 0 → `freeze_if`=1 and `flush_id_exe`=1 in both cycles, `flush_if_id`=0; `stall_cnt`=2, `flush_cnt`=0.
- Branch beats hazard: `hazard`=1 and `branch_taken`=1 in the same cycle → `flush_if_id`=1, `flush_id_exe`=1, `freeze_if`=0; `flush_cnt`=1 and `stall_cnt` unchanged.
- Memory wait: `mem_req`=1, `mem_ready` pulsed 3 cycles after `mem_start` → `mem_start` is a 1-cycle pulse; `freeze_all`=1 for 3 cycles and 0 in the ready cycle; `stall_cnt`=3; a `branch_taken`=1 held during the wait produces no flush until back in RUN.
- Back-to-back access: `mem_req` held at 1 across two accesses, `mem_ready` 1 cycle after each start → `mem_start` pulses exactly 2 cycles apart; `mem_busy` high in alternate cycles.
- Saturation and clear: CNT_W=4, `hazard`=1 for 20 cycles → `stall_cnt` stops at 15. Then `cnt_clr`=1 with `hazard`=1 → `stall_cnt`=0 next cycle; FSM state unaffected.
